exc_ctrl: RTL and testbench

Precise-exception controller for the 5-stage MIPS pipeline: tracks per-instruction exception records alongside F/D/E/M, prioritizes them, and commits exactly one event at M. It drives the CP0 exception/ERET update port (exception, excCode, BadVAddr, EPC source, BD) and the pipeline flush/PC-redirect port. It is the producer side of the CP0 exception interface; CP0 consumes its outputs and returns `interrupt` and `cp0_epc`.

---
 rtl/exc_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_exc_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: precise-exception controller for the 5-stage MIPS pipeline.
//
// Carries one exception record per instruction through F/D/E/M, lets the
// first detected cause win, and commits at most one event (exception,
// interrupt or ERET) when the instruction reaches M. Drives the CP0 update
// port and the pipeline flush / PC-redirect port. If a data-bus transaction
// is outstanding at commit, the redirect is held back in DRAIN until the bus
// goes idle.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   stall                       freeze pipeline (records hold, no commit)
//   f_valid, f_pc, f_adel       fetch-stage instruction and fetch AdEL
//   d_ri, d_sys, d_bp           decode-stage causes
//   d_eret, d_bd                decode-stage ERET flag, delay-slot flag
//   e_ov                        execute-stage overflow
//   m_adel, m_ades, m_addr      memory-stage address errors and data address
//   mem_busy                    outstanding data-bus transaction
//   interrupt, cp0_epc          from CP0
//   exception, m_excCode        CP0 exception strobe and {1'b0, ExcCode}
//   isBadAddr, invalid_addr     BadVAddr write enable and value
//   excPC, inDelaySlot          committing PC (raw) and BD flag
//   ERET2pc                     CP0 EXL-clear strobe
//   flush                       kill F/D/E/M contents
//   redirect_valid, redirect_pc PC override

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_adel,
  input  logic        d_ri,
  input  logic        d_sys,
  input  logic        d_bp,
  input  logic        d_eret,
  input  logic        d_bd,
  input  logic        e_ov,
  input  logic        m_adel,
  input  logic        m_ades,
  input  logic [31:0] m_addr,
  input  logic        mem_busy,
  input  logic        interrupt,
  input  logic [31:0] cp0_epc,
  output logic        exception,
  output logic [5:0]  m_excCode,
  output logic        isBadAddr,
  output logic [31:0] invalid_addr,
  output logic [31:0] excPC,
  output logic        inDelaySlot,
  output logic        ERET2pc,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcSys  = 5'd8;
  localparam logic [4:0] ExcBp   = 5'd9;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  typedef struct packed {
    logic        valid;
    logic        exc;
    logic [4:0]  code;
    logic        bad;
    logic [31:0] badaddr;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
  } rec_t;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  rec_t   f_rec, d_out, e_out, m_rec;
  rec_t   d_q, e_q, m_q;
  state_e state_q, state_d;
  logic [31:0] target_q, target_d;

  logic        commit, take_exc, take_eret;
  logic [31:0] event_tgt;

  // Fetch record straight from the fetch inputs.
  always_comb begin
    f_rec       = '0;
    f_rec.valid = f_valid;
    f_rec.pc    = f_pc;
    if (f_valid && f_adel) begin
      f_rec.exc     = 1'b1;
      f_rec.code    = ExcAdel;
      f_rec.bad     = 1'b1;
      f_rec.badaddr = f_pc;
    end
  end

  // Decode: annotate bd/eret and add decode causes unless an earlier one exists.
  always_comb begin
    d_out = d_q;
    if (d_q.valid) begin
      d_out.bd   = d_bd;
      d_out.eret = d_eret;
      if (!d_q.exc) begin
        if (d_ri) begin
          d_out.exc  = 1'b1;
          d_out.code = ExcRi;
        end else if (d_sys) begin
          d_out.exc  = 1'b1;
          d_out.code = ExcSys;
        end else if (d_bp) begin
          d_out.exc  = 1'b1;
          d_out.code = ExcBp;
        end
      end
    end
  end

  always_comb begin
    e_out = e_q;
    if (e_q.valid && !e_q.exc && e_ov) begin
      e_out.exc  = 1'b1;
      e_out.code = ExcOv;
    end
  end

  // Memory-stage causes are folded in combinationally so they commit this cycle.
  always_comb begin
    m_rec = m_q;
    if (m_q.valid && !m_q.exc) begin
      if (m_adel) begin
        m_rec.exc     = 1'b1;
        m_rec.code    = ExcAdel;
        m_rec.bad     = 1'b1;
        m_rec.badaddr = m_addr;
      end else if (m_ades) begin
        m_rec.exc     = 1'b1;
        m_rec.code    = ExcAdes;
        m_rec.bad     = 1'b1;
        m_rec.badaddr = m_addr;
      end
    end
  end

  // Record pipeline. Flush beats stall so a committing M record is also killed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= '0;
      e_q <= '0;
      m_q <= '0;
    end else if (flush) begin
      d_q <= '0;
      e_q <= '0;
      m_q <= '0;
    end else if (!stall) begin
      d_q <= f_rec;
      e_q <= d_out;
      m_q <= e_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Interrupts override the M record's own cause; ERET only if nothing else.
  always_comb begin
    commit    = m_rec.valid && !stall && (state_q == StIdle);
    take_exc  = commit && (interrupt || m_rec.exc);
    take_eret = commit && !interrupt && !m_rec.exc && m_rec.eret;
    event_tgt = take_exc ? EXC_VECTOR : cp0_epc;
  end

  always_comb begin
    exception    = 1'b0;
    m_excCode    = '0;
    isBadAddr    = 1'b0;
    invalid_addr = '0;
    excPC        = '0;
    inDelaySlot  = 1'b0;
    ERET2pc      = take_eret;
    if (take_exc) begin
      exception = 1'b1;
      m_excCode = {1'b0, interrupt ? ExcInt : m_rec.code};
      isBadAddr = !interrupt && m_rec.bad;
      if (!interrupt && m_rec.bad) begin
        invalid_addr = m_rec.badaddr;
      end
    end
    if (take_exc || take_eret) begin
      excPC       = m_rec.pc;
      inDelaySlot = m_rec.bd;
    end
  end

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      StIdle: begin
        if (take_exc || take_eret) begin
          flush = 1'b1;
          if (!mem_busy) begin
            redirect_valid = 1'b1;
            redirect_pc    = event_tgt;
          end else begin
            target_d = event_tgt;
            state_d  = StDrain;
          end
        end
      end
      StDrain: begin
        flush = 1'b1;
        if (!mem_busy) begin
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, f_valid, f_adel;
  logic [31:0] f_pc;
  logic        d_ri, d_sys, d_bp, d_eret, d_bd, e_ov;
  logic        m_adel, m_ades, mem_busy, interrupt;
  logic [31:0] m_addr, cp0_epc;
  logic        exception, isBadAddr, inDelaySlot, ERET2pc, flush, redirect_valid;
  logic [5:0]  m_excCode;
  logic [31:0] invalid_addr, excPC, redirect_pc;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .f_valid(f_valid), .f_pc(f_pc), .f_adel(f_adel),
    .d_ri(d_ri), .d_sys(d_sys), .d_bp(d_bp), .d_eret(d_eret), .d_bd(d_bd),
    .e_ov(e_ov), .m_adel(m_adel), .m_ades(m_ades), .m_addr(m_addr),
    .mem_busy(mem_busy), .interrupt(interrupt), .cp0_epc(cp0_epc),
    .exception(exception), .m_excCode(m_excCode), .isBadAddr(isBadAddr),
    .invalid_addr(invalid_addr), .excPC(excPC), .inDelaySlot(inDelaySlot),
    .ERET2pc(ERET2pc), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] Vec = 32'hBFC00380;

  typedef struct {
    logic        exc;
    logic [5:0]  code;
    logic        isbad;
    logic [31:0] badaddr;
    logic [31:0] excpc;
    logic        bd;
    logic        eret;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] rd_q[$];
  ev_t         mon_e;
  logic [31:0] mon_rd;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_ev(input logic exc, input logic [5:0] code, input logic isbad,
                         input logic [31:0] badaddr, input logic [31:0] excpc,
                         input logic bd, input logic eret);
    ev_t e;
    e.exc = exc; e.code = code; e.isbad = isbad; e.badaddr = badaddr;
    e.excpc = excpc; e.bd = bd; e.eret = eret;
    ev_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Walks one instruction F->D->E->M, applying causes at their stage; returns in the M cycle.
  task automatic issue(input logic [31:0] pc, input logic fadel, input logic dri,
                       input logic dsys, input logic dbp, input logic deret,
                       input logic dbd, input logic eov, input logic madel,
                       input logic mades, input logic [31:0] maddr,
                       input logic intr, input logic busy);
    f_valid = 1'b1; f_pc = pc; f_adel = fadel;
    cyc();
    f_valid = 1'b0; f_pc = '0; f_adel = 1'b0;
    d_ri = dri; d_sys = dsys; d_bp = dbp; d_eret = deret; d_bd = dbd;
    cyc();
    d_ri = 1'b0; d_sys = 1'b0; d_bp = 1'b0; d_eret = 1'b0; d_bd = 1'b0;
    e_ov = eov;
    cyc();
    e_ov = 1'b0;
    m_adel = madel; m_ades = mades; m_addr = maddr; interrupt = intr; mem_busy = busy;
  endtask

  task automatic clear_m();
    m_adel = 1'b0; m_ades = 1'b0; m_addr = '0; interrupt = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_redirect"}, 32'(redirect_valid), 32'd0);
  endtask

  // Scoreboard: every strobe / redirect must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (exception || ERET2pc) begin
        check("strobe_exclusive", 32'(exception & ERET2pc), 32'd0);
        if (ev_q.size() == 0) begin
          check("unexpected_strobe", 32'(exception | ERET2pc), 32'd0);
        end else begin
          mon_e = ev_q.pop_front();
          check("exception", 32'(exception), 32'(mon_e.exc));
          check("ERET2pc", 32'(ERET2pc), 32'(mon_e.eret));
          check("m_excCode", 32'(m_excCode), 32'(mon_e.code));
          if (mon_e.exc) begin
            check("isBadAddr", 32'(isBadAddr), 32'(mon_e.isbad));
            if (mon_e.isbad) check("invalid_addr", invalid_addr, mon_e.badaddr);
            check("excPC", excPC, mon_e.excpc);
            check("inDelaySlot", 32'(inDelaySlot), 32'(mon_e.bd));
          end
        end
      end
      if (redirect_valid) begin
        if (rd_q.size() == 0) begin
          check("unexpected_redirect", 32'(redirect_valid), 32'd0);
        end else begin
          mon_rd = rd_q.pop_front();
          check("redirect_pc", redirect_pc, mon_rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; f_valid = 1'b0; f_pc = '0; f_adel = 1'b0;
    d_ri = 1'b0; d_sys = 1'b0; d_bp = 1'b0; d_eret = 1'b0; d_bd = 1'b0; e_ov = 1'b0;
    m_adel = 1'b0; m_ades = 1'b0; m_addr = '0; mem_busy = 1'b0; interrupt = 1'b0;
    cp0_epc = '0;
    cyc();
    @(negedge clk);
    check("rst_exception", 32'(exception), 32'd0);
    check("rst_code", 32'(m_excCode), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check_quiet("rst");
    cyc();
    reset = 1'b0;
    cyc();

    // Overflow detected in E, commits in M.
    push_ev(1, 6'd12, 0, 0, 32'h80000010, 0, 0);
    rd_q.push_back(Vec);
    issue(32'h80000010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("ov_flush", 32'(flush), 32'd1);
    check("ov_redirect", 32'(redirect_valid), 32'd1);
    cyc(); clear_m();
    @(negedge clk);
    check_quiet("ov_after");
    cyc();

    // Fetch AdEL wins over a later RI.
    push_ev(1, 6'd4, 1, 32'h80000003, 32'h80000003, 0, 0);
    rd_q.push_back(Vec);
    issue(32'h80000003, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc(); clear_m();

    // Delay-slot store with AdES.
    push_ev(1, 6'd5, 1, 32'h00001001, 32'h80000100, 1, 0);
    rd_q.push_back(Vec);
    issue(32'h80000100, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h00001001, 0, 0);
    @(negedge clk);
    cyc(); clear_m();

    // m_adel takes precedence over m_ades.
    push_ev(1, 6'd4, 1, 32'h00002002, 32'h80000180, 0, 0);
    rd_q.push_back(Vec);
    issue(32'h80000180, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h00002002, 0, 0);
    @(negedge clk);
    cyc(); clear_m();

    // Interrupt over a syscall, bus busy for 3 cycles.
    push_ev(1, 6'd0, 0, 0, 32'h80000200, 0, 0);
    rd_q.push_back(Vec);
    issue(32'h80000200, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    check("int_c0_flush", 32'(flush), 32'd1);
    check("int_c0_redirect", 32'(redirect_valid), 32'd0);
    cyc(); clear_m();
    @(negedge clk);
    check("int_c1_flush", 32'(flush), 32'd1);
    check("int_c1_redirect", 32'(redirect_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("int_c2_flush", 32'(flush), 32'd1);
    check("int_c2_redirect", 32'(redirect_valid), 32'd0);
    cyc(); mem_busy = 1'b0;
    @(negedge clk);
    check("int_c3_flush", 32'(flush), 32'd1);
    check("int_c3_redirect", 32'(redirect_valid), 32'd1);
    cyc();
    @(negedge clk);
    check_quiet("int_after");
    cyc();

    // ERET returns to cp0_epc.
    cp0_epc = 32'h80001234;
    push_ev(0, 6'd0, 0, 0, 32'h80000300, 0, 1);
    rd_q.push_back(32'h80001234);
    issue(32'h80000300, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("eret_flush", 32'(flush), 32'd1);
    cyc(); clear_m();

    // ERET carrying a fetch AdEL commits as an exception.
    push_ev(1, 6'd4, 1, 32'h80000341, 32'h80000341, 0, 0);
    rd_q.push_back(Vec);
    issue(32'h80000341, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc(); clear_m();

    // Interrupt with only bubbles in the pipe never commits.
    interrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bubble_int_exception", 32'(exception), 32'd0);
      cyc();
    end
    interrupt = 1'b0;

    // Stall holds a pending M exception (and masks interrupt) for 5 cycles.
    push_ev(1, 6'd12, 0, 0, 32'h80000400, 0, 0);
    rd_q.push_back(Vec);
    issue(32'h80000400, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    stall = 1'b1; interrupt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_exception", 32'(exception), 32'd0);
      check("stall_flush", 32'(flush), 32'd0);
      cyc();
    end
    stall = 1'b0; interrupt = 1'b0;
    @(negedge clk);
    check("stall_release_exception", 32'(exception), 32'd1);
    cyc();
    @(negedge clk);
    check("stall_single_strobe", 32'(exception), 32'd0);
    cyc();

    // Reset in DRAIN: no redirect ever appears.
    push_ev(1, 6'd12, 0, 0, 32'h80000500, 0, 0);
    issue(32'h80000500, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("drain_c0_redirect", 32'(redirect_valid), 32'd0);
    cyc(); clear_m();
    @(negedge clk);
    check("drain_c1_flush", 32'(flush), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_drain_flush", 32'(flush), 32'd0);
    check("rst_drain_exception", 32'(exception), 32'd0);
    check("rst_drain_redirect_pc", redirect_pc, 32'd0);
    cyc();
    reset = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    check_quiet("rst_drain_after");
    cyc();

    repeat (3) cyc();
    check("events_left", 32'(ev_q.size()), 32'd0);
    check("redirects_left", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
